loss_feeder: RTL

Transmit side of the loss-block column interface. On a start command it reads N-wide activation (H) and target (Y) rows from two synchronous-read buffers. It drives them into the per-column loss units with a diagonal skew: column i lags column 0 by i cycles, matching the systolic output timing. There is no backpressure; the loss units consume one element per column per cycle.

---
 rtl/loss_feeder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/loss_feeder.sv
// Feeds H/Y rows from two synchronous-read buffers into the loss-block columns,
// skewing column i by i cycles to line up with the systolic output timing.
module loss_feeder #(
  parameter int unsigned N      = 2,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       num_rows,
  input  logic [ADDR_W-1:0]       h_base_addr,
  input  logic [ADDR_W-1:0]       y_base_addr,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_h_addr,
  output logic [ADDR_W-1:0]       mem_y_addr,
  input  logic [N-1:0][15:0]      mem_h_data,
  input  logic [N-1:0][15:0]      mem_y_data,
  output logic [N-1:0][15:0]      H_out,
  output logic [N-1:0][15:0]      Y_out,
  output logic [N-1:0]            valid_out,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned DW    = 16;
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]   rows_q, rows_d;
  logic [ADDR_W-1:0]   h_base_q, h_base_d;
  logic [ADDR_W-1:0]   y_base_q, y_base_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   h_addr_q, h_addr_d;
  logic [ADDR_W-1:0]   y_addr_q, y_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_vld_q;

  // Control state and registered memory/handshake outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      rows_q   <= '0;
      h_base_q <= '0;
      y_base_q <= '0;
      cnt_q    <= '0;
      rd_en_q  <= 1'b0;
      h_addr_q <= '0;
      y_addr_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      rows_q   <= rows_d;
      h_base_q <= h_base_d;
      y_base_q <= y_base_d;
      cnt_q    <= cnt_d;
      rd_en_q  <= rd_en_d;
      h_addr_q <= h_addr_d;
      y_addr_q <= y_addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_vld_q <= rd_en_q;
    end
  end

  // A zero-row start passes through one silent DRAIN cycle so done lands
  // two cycles after start without ever raising busy.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    rows_d   = rows_q;
    h_base_d = h_base_q;
    y_base_d = y_base_q;
    cnt_d    = cnt_q;
    rd_en_d  = 1'b0;
    h_addr_d = h_addr_q;
    y_addr_d = y_addr_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d   = num_rows;
          h_base_d = h_base_addr;
          y_base_d = y_base_addr;
          row_d    = '0;
          if (num_rows == '0) begin
            state_d = S_DRAIN;
            cnt_d   = CNT_W'(N);
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        busy_d   = 1'b1;
        rd_en_d  = 1'b1;
        h_addr_d = h_base_q + row_q;
        y_addr_d = y_base_q + row_q;
        row_d    = row_q + ADDR_W'(1);
        if (row_q == rows_q - ADDR_W'(1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        busy_d = (rows_q != '0);
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_rd_en  = rd_en_q;
  assign mem_h_addr = h_addr_q;
  assign mem_y_addr = y_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Per-column skew line: stage 0 captures returned data, column i adds i stages
  for (genvar i = 0; i < N; i++) begin : g_col
    logic [i:0]    v_q;
    logic [DW-1:0] h_q [i+1];
    logic [DW-1:0] y_q [i+1];

    always_ff @(posedge clk) begin
      if (!rst) begin
        v_q <= '0;
        for (int s = 0; s <= i; s++) begin
          h_q[s] <= '0;
          y_q[s] <= '0;
        end
      end else begin
        v_q[0] <= rd_vld_q;
        h_q[0] <= rd_vld_q ? mem_h_data[i] : '0;
        y_q[0] <= rd_vld_q ? mem_y_data[i] : '0;
        for (int s = 1; s <= i; s++) begin
          v_q[s] <= v_q[s-1];
          h_q[s] <= h_q[s-1];
          y_q[s] <= y_q[s-1];
        end
      end
    end

    assign valid_out[i] = v_q[i];
    assign H_out[i]     = h_q[i];
    assign Y_out[i]     = y_q[i];
  end

endmodule
